uart_tx_framer: RTL
===================

Name: uart_tx_framer

Overview:
- Serial UART transmitter directly downstream of the phase-accumulator baud generator.
- Consumes its single-cycle `baud_tick` strobe (one strobe per bit period) and serialises parallel bytes onto a TX line.
- Upstream logic (FIFO or command engine) presents bytes on a valid/ready handshake.
- Frame format: 1 start bit, DATA_BITS LSB-first, optional parity bit, 1 or 2 stop bits.

Parameters:
- DATA_BITS, 8, payload width per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2. Any other value, or DATA_BITS outside 5..9, is an elaboration error.

Ports:
- clk  input  1  system clock, same domain as the baud generator.
- reset  input  1  asynchronous, active-low reset.
- baud_tick  input  1  one-clk-wide bit-period strobe from the baud generator.
- tx_data  input  DATA_BITS  byte to send; sampled on handshake.
- tx_valid  input  1  upstream has data.
- tx_ready  output  1  block can accept; high only in IDLE.
- tx  output  1  serial line; registered; idle high.
- tx_busy  output  1  high whenever state is not IDLE.
- tx_done  output  1  one-clk pulse after the last stop bit completes.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - tx=1, tx_ready=1, tx_busy=0, tx_done=0.
  - State=IDLE; shift register, bit counter and parity accumulator cleared.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 with no glitch to 0.
- Handshake:
  - Transfer occurs on a rising edge where tx_valid=1 and tx_ready=1.
  - tx_data is latched into the shift register on that edge.
  - tx_ready drops the following cycle.
  - tx_valid with tx_ready=0 is ignored; upstream holds data.
- States: IDLE, ARMED, START, DATA, PARITY, STOP.
  - IDLE: on transfer -> ARMED.
  - ARMED: waits for the first baud_tick strictly after the transfer cycle. A tick coincident with the transfer edge is ignored. On the tick -> START, tx=0 from the next cycle. This keeps the start bit a full bit period.
  - START: on baud_tick -> DATA; tx = bit 0.
  - DATA: on each baud_tick shift right and drive the next bit.
    - After DATA_BITS bits: -> PARITY if PARITY!=0, else -> STOP with tx=1.
  - PARITY: tx = XOR of the data bits for even; inverted XOR for odd. On baud_tick -> STOP, tx=1.
  - STOP: counts STOP_BITS ticks. On the final tick -> IDLE; tx_done=1 for exactly one cycle; tx_ready=1 in the same cycle.
- All line transitions occur on the clk edge after a baud_tick. Each bit therefore lasts exactly one tick-to-tick interval.
- No back-to-back pipelining: the next transfer is accepted no earlier than the cycle tx_done is high. Its start bit begins on the next tick after that, giving zero extra idle bit periods when tx_valid is held.
- baud_tick is ignored in IDLE.
- tx_data changes after the transfer do not affect the frame in flight.
- Latency: transfer to start-bit assertion = (cycles to next tick) + 1 clk.

Test Plan:
- Reset defaults: hold reset=0 for 5 clks with tx_valid=1 -> tx=1, tx_ready=1, tx_busy=0, tx_done=0 throughout.
- 8N1 frame: defaults, baud_tick every 16 clks, send 0xA5.
  - Per-tick line sequence must be 0,1,0,1,0,0,1,0,1,1.
  - tx_done pulses once, 1 clk after the stop-bit tick.
  - Total busy time is 10 tick periods plus the arm wait.
- Parity modes: DATA_BITS=8, PARITY=2, send 0xA5 -> parity bit 0. PARITY=1, send 0xA5 -> parity bit 1. PARITY=1, send 0x01 -> parity bit 0. STOP_BITS=2 -> two high bit periods before tx_done.
- Coincident tick: assert tx_valid in the same cycle as baud_tick -> that tick is ignored; start bit begins after the next tick and lasts a full period.
- Back-to-back: hold tx_valid with 0x55 then 0x0F -> second accepted in the tx_done cycle; its start bit follows immediately after the first stop bit; tx_data changes mid-frame do not corrupt the line.
- Mid-frame reset: pulse reset=0 during data bit 3 -> tx=1 asynchronously, state IDLE, no tx_done. The next send of 0x3C produces a clean frame 0,0,0,1,1,1,1,0,0,1.

Source files
------------

// File: rtl/uart_tx_framer_if.sv
// Byte handshake between an upstream byte source and the UART transmit framer.
interface uart_tx_framer_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmitter: frames handshake bytes into start/data/parity/stop bits,
// advancing one bit per baud_tick strobe from the baud generator.
module uart_tx_framer #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               baud_tick,
  uart_tx_framer_if.slave    up,
  output logic               tx,
  output logic               tx_busy,
  output logic               tx_done
);

  if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) || PARITY > 2) begin : g_bad_param
    $error("uart_tx_framer: illegal DATA_BITS/PARITY/STOP_BITS");
  end

  localparam int unsigned CNT_W    = $clog2(DATA_BITS);
  localparam logic        USE_PAR  = 1'(PARITY != 0);
  localparam logic        PAR_ODD  = 1'(PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;

  assign tx          = tx_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign up.tx_ready = ready_q;

  // Single-process FSM; every line change happens on the edge that sees baud_tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (up.tx_valid && ready_q) begin
            shift_q <= up.tx_data;
            par_q   <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_ARMED;
          end
        end
        // A tick on the transfer edge was seen in IDLE, so the start bit is always full length.
        S_ARMED: begin
          if (baud_tick) begin
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_tick) begin
            tx_q    <= shift_q[0];
            par_q   <= par_q ^ shift_q[0];
            shift_q <= shift_q >> 1;
            cnt_q   <= '0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
              cnt_q <= '0;
              if (USE_PAR) begin
                tx_q    <= par_q ^ PAR_ODD;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              tx_q    <= shift_q[0];
              par_q   <= par_q ^ shift_q[0];
              shift_q <= shift_q >> 1;
              cnt_q   <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (baud_tick) begin
            tx_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (baud_tick) begin
            if (cnt_q == CNT_W'(STOP_BITS - 1)) begin
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
